// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM states and status-bit layout shared by the SPI flash controller and responder
package spi_flash_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RES  = 8'hAB;
  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_CMD  = 3'd1;
  localparam state_t S_ADDR = 3'd2;
  localparam state_t S_RD   = 3'd3;
  localparam state_t S_PROG = 3'd4;
  localparam state_t S_STAT = 3'd5;
  localparam state_t S_IGN  = 3'd6;
  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    status_byte = 8'h00;
    status_byte[ST_WEL] = wel;
    status_byte[ST_WIP] = wip;
  endfunction
endpackage

// File: rtl/spi_flash_emu_if.sv
// spi_flash_emu_if: four-wire SPI bus between controller (master) and flash (slave)
interface spi_flash_emu_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_di;
  logic spi_do;
  modport master(output spi_clk, output spi_cs, output spi_di, input spi_do);
  modport slave(input spi_clk, input spi_cs, input spi_di, output spi_do);
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizers for SPI pins with rise/fall pulses in the clk domain
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_di,
  output logic di,
  output logic clk_rise,
  output logic clk_fall,
  output logic cs_rise,
  output logic cs_fall
);
  logic [2:0] qc, qs;
  logic [1:0] qd;
  // CS resets low so a select held low through reset never looks like a fresh fall
  always_ff @(posedge clk) begin
    if (rst) begin
      qc <= '0;
      qs <= '0;
      qd <= '0;
    end else begin
      qc <= {qc[1:0], spi_clk};
      qs <= {qs[1:0], spi_cs};
      qd <= {qd[0], spi_di};
    end
  end
  assign di       = qd[1];
  assign clk_rise = qc[1] & ~qc[2];
  assign clk_fall = ~qc[1] & qc[2];
  assign cs_rise  = qs[1] & ~qs[2];
  assign cs_fall  = ~qs[1] & qs[2];
endmodule

// File: rtl/spi_flash_emu.sv
// spi_flash_emu: SPI NOR flash responder backed by a small flop window with a WIP busy timer
module spi_flash_emu
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR    = 24'h1ffd80,
  parameter int          MEM_BYTES    = 16,
  parameter int          ERASE_CYCLES = 4096,
  parameter int          PROG_CYCLES  = 256
) (
  input  logic            clk,
  input  logic            rst,
  spi_flash_emu_if.slave  spi,
  output logic            busy,
  output logic            wel,
  output logic [7:0]      last_cmd
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CMAX = ERASE_CYCLES > PROG_CYCLES ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  logic di, sr, sf, cr, cf;
  state_t state;
  logic [6:0] sh;
  logic [2:0] bcnt;
  logic [5:0] nbits;
  logic [23:0] addr, off;
  logic [7:0] opc, op, rdb, stat;
  logic got, inwin;
  logic [CW-1:0] cnt;
  logic [7:0] mem [0:MEM_BYTES-1];
  spi_edge_sync u_sync (
    .clk(clk), .rst(rst), .spi_clk(spi.spi_clk), .spi_cs(spi.spi_cs), .spi_di(spi.spi_di),
    .di(di), .clk_rise(sr), .clk_fall(sf), .cs_rise(cr), .cs_fall(cf)
  );
  assign busy = cnt != '0;
  always_comb begin
    op    = {sh, di};
    off   = addr - BASE_ADDR;
    inwin = off < 24'(MEM_BYTES);
    rdb   = inwin ? mem[off[AW-1:0]] : 8'hFF;
    stat  = status_byte(wel, busy);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sh       <= '0;
      bcnt     <= '0;
      nbits    <= '0;
      addr     <= '0;
      opc      <= '0;
      got      <= 1'b0;
      cnt      <= '0;
      wel      <= 1'b0;
      last_cmd <= '0;
      spi.spi_do <= 1'b1;
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'hFF;
    end else begin
      if (busy) cnt <= cnt - CW'(1);
      if (cr) begin
        state <= S_IDLE;
        spi.spi_do <= 1'b1;
        if (nbits == 6'd8 && opc == OP_WREN) wel <= 1'b1;
        if (nbits == 6'd8 && opc == OP_WRDI) wel <= 1'b0;
        if (got) begin
          cnt <= CW'(PROG_CYCLES);
          wel <= 1'b0;
        end
        // erase commits only on exactly opcode + 24 address bits
        if (opc == OP_SE && nbits == 6'd32 && wel) begin
          cnt <= CW'(ERASE_CYCLES);
          wel <= 1'b0;
          if (addr[23:12] == BASE_ADDR[23:12])
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'hFF;
        end
      end else if (cf) begin
        state <= S_CMD;
        bcnt  <= '0;
        nbits <= '0;
        opc   <= '0;
        got   <= 1'b0;
      end else if (state != S_IDLE && sr) begin
        sh   <= op[6:0];
        bcnt <= bcnt + 3'd1;
        if (nbits != '1) nbits <= nbits + 6'd1;
        if (state == S_CMD && bcnt == 3'd7) begin
          if (busy && op != OP_RDSR) state <= S_IGN;
          else begin
            last_cmd <= op;
            opc      <= op;
            state    <= op == OP_RES ? S_IGN :
                        op == OP_RDSR ? S_STAT :
                        (op == OP_READ || op == OP_PP || op == OP_SE) ? S_ADDR : S_IGN;
          end
        end
        if (state == S_ADDR) begin
          addr <= {addr[22:0], di};
          if (nbits == 6'd31)
            state <= opc == OP_READ ? S_RD : (opc == OP_PP && wel) ? S_PROG : S_IGN;
        end
        if (state == S_RD && bcnt == 3'd7) addr <= addr + 24'd1;
        if (state == S_PROG && bcnt == 3'd7) begin
          if (inwin) mem[off[AW-1:0]] <= mem[off[AW-1:0]] & op;
          addr[7:0] <= addr[7:0] + 8'd1;
          got <= 1'b1;
        end
      end else if (state != S_IDLE && sf) begin
        spi.spi_do <= state == S_RD ? rdb[~bcnt] : state == S_STAT ? stat[~bcnt] : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_emu.sv
// tb_spi_flash_emu: directed table, corner sequences and model-checked random traffic for spi_flash_emu
module tb_spi_flash_emu;
  localparam logic [23:0] BASE = 24'h1ffd80;
  localparam int PROG = 256;
  localparam int ERASE = 4096;
  typedef struct {
    string       nm;
    logic [63:0] tx;
    int          nb;
    bit          rd;
    logic [31:0] ex;
    logic        w;
    int          b;
    logic [7:0]  lc;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  logic busy, wel;
  logic [7:0] last_cmd;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  vec_t vq[$];
  logic [7:0] mm [0:15];
  logic mwel;
  spi_flash_emu_if bus();
  spi_flash_emu #(.BASE_ADDR(BASE), .MEM_BYTES(16), .ERASE_CYCLES(ERASE), .PROG_CYCLES(PROG)) dut (
    .clk(clk), .rst(rst), .spi(bus), .busy(busy), .wel(wel), .last_cmd(last_cmd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic shift(input logic [63:0] tx, input int nb, output logic [63:0] rx);
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      bus.spi_di = tx[63-i];
      wclk(4);
      rx = {rx[62:0], bus.spi_do};
      bus.spi_clk = 1'b1;
      wclk(4);
      bus.spi_clk = 1'b0;
    end
  endtask
  task automatic meas(input int lim, output int n);
    n = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
  endtask
  task automatic txn(input logic [63:0] tx, input int nb, input int bsy, output logic [63:0] rx, output int n);
    bus.spi_cs = 1'b0;
    wclk(4);
    shift(tx, nb, rx);
    wclk(4);
    bus.spi_cs = 1'b1;
    n = 0;
    if (bsy >= 0) meas(bsy + 40, n);
    wclk(8);
  endtask
  task automatic add(input string nm, input logic [63:0] tx, input int nb, input bit rd,
                     input logic [31:0] ex, input logic w, input int b, input logic [7:0] lc);
    vq.push_back('{nm, tx, nb, rd, ex, w, b, lc});
  endtask
  function automatic logic [7:0] mrd(input logic [23:0] a);
    int o;
    o = int'(a) - int'(BASE);
    return (o >= 0 && o < 16) ? mm[o] : 8'hFF;
  endfunction
  task automatic mwr(input logic [23:0] a, input logic [7:0] b);
    int o;
    o = int'(a) - int'(BASE);
    if (o >= 0 && o < 16) mm[o] = mm[o] & b;
  endtask
  initial begin
    logic [63:0] rx, tx;
    logic [31:0] ex, d;
    logic [23:0] a, ai;
    logic [7:0] s;
    int n, nb, eb, k, np, t0, erases;
    bit rd, bad;
    bus.spi_clk = 1'b0;
    bus.spi_cs = 1'b1;
    bus.spi_di = 1'b0;
    wclk(5);
    chk("rst_do", 64'(bus.spi_do), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wel", 64'(wel), 64'd0);
    chk("rst_lc", 64'(last_cmd), 64'd0);
    rst = 1'b0;
    wclk(8);
    add("rd_reset",  {8'h03, 24'h1ffd80, 32'h0}, 64, 1, 32'hFFFFFFFF, 0, 0, 8'h03);
    add("wren",      {8'h06, 56'h0}, 8, 0, 0, 1, 0, 8'h06);
    add("pp4",       {8'h02, 24'h1ffd84, 32'hB02E7F1E}, 64, 0, 0, 0, PROG, 8'h02);
    add("rd_pp4",    {8'h03, 24'h1ffd84, 32'h0}, 64, 1, 32'hB02E7F1E, 0, 0, 8'h03);
    add("pp_nowel",  {8'h02, 24'h1ffd80, 8'h00, 24'h0}, 40, 0, 0, 0, 0, 8'h02);
    add("rd_nowel",  {8'h03, 24'h1ffd80, 32'h0}, 64, 1, 32'hFFFFFFFF, 0, 0, 8'h03);
    add("wren2",     {8'h06, 56'h0}, 8, 0, 0, 1, 0, 8'h06);
    add("pp_f0",     {8'h02, 24'h1ffd88, 8'hF0, 24'h0}, 40, 0, 0, 0, PROG, 8'h02);
    add("wren3",     {8'h06, 56'h0}, 8, 0, 0, 1, 0, 8'h06);
    add("pp_0f",     {8'h02, 24'h1ffd88, 8'h0F, 24'h0}, 40, 0, 0, 0, PROG, 8'h02);
    add("rd_and",    {8'h03, 24'h1ffd88, 32'h0}, 64, 1, 32'h00FFFFFF, 0, 0, 8'h03);
    add("wren4",     {8'h06, 56'h0}, 8, 0, 0, 1, 0, 8'h06);
    add("se_far",    {8'h20, 24'h100000, 32'h0}, 32, 0, 0, 0, ERASE, 8'h20);
    add("rd_far",    {8'h03, 24'h1ffd84, 32'h0}, 64, 1, 32'hB02E7F1E, 0, 0, 8'h03);
    add("wren5",     {8'h06, 56'h0}, 8, 0, 0, 1, 0, 8'h06);
    add("se_short",  {8'h20, 24'h1ffd80, 32'h0}, 28, 0, 0, 1, 0, 8'h20);
    add("rdsr_wel",  {8'h05, 56'h0}, 16, 1, 32'h0000FF02, 1, 0, 8'h05);
    add("wrdi",      {8'h04, 56'h0}, 8, 0, 0, 0, 0, 8'h04);
    add("rdsr_0",    {8'h05, 56'h0}, 16, 1, 32'h0000FF00, 0, 0, 8'h05);
    add("rd_cross",  {8'h03, 24'h1ffd86, 32'h0}, 64, 1, 32'h7F1E00FF, 0, 0, 8'h03);
    add("rd_edge",   {8'h03, 24'h1ffd8e, 32'h0}, 64, 1, 32'hFFFFFFFF, 0, 0, 8'h03);
    add("wren6",     {8'h06, 56'h0}, 8, 0, 0, 1, 0, 8'h06);
    add("wrdi9",     {8'h04, 56'h0}, 9, 0, 0, 1, 0, 8'h04);
    add("pp_edge",   {8'h02, 24'h1ffd8f, 8'hAA, 8'h55, 16'h0}, 48, 0, 0, 0, PROG, 8'h02);
    add("rd_pedge",  {8'h03, 24'h1ffd8e, 32'h0}, 64, 1, 32'hFFAAFFFF, 0, 0, 8'h03);
    foreach (vq[i]) begin
      txn(vq[i].tx, vq[i].nb, vq[i].b, rx, n);
      if (vq[i].rd) chk({vq[i].nm, "_rx"}, 64'(rx[31:0]), 64'(vq[i].ex));
      chk({vq[i].nm, "_busy"}, 64'(n), 64'(vq[i].b));
      chk({vq[i].nm, "_wel"}, 64'(wel), 64'(vq[i].w));
      chk({vq[i].nm, "_lc"}, 64'(last_cmd), 64'(vq[i].lc));
    end
    txn({8'h06, 56'h0}, 8, 0, rx, n);
    txn({8'h20, 24'h1ffd80, 32'h0}, 32, -1, rx, n);
    t0 = cyc;
    txn({8'h03, 24'h1ffd80, 32'h0}, 64, -1, rx, n);
    chk("busy_rd_rx", rx, 64'hFFFFFFFFFFFFFFFF);
    chk("busy_rd_lc", 64'(last_cmd), 64'h20);
    chk("erase_wel", 64'(wel), 64'd0);
    bad = 0;
    s = 8'hEE;
    for (np = 0; np < 60; np++) begin
      txn({8'h05, 56'h0}, 16, -1, rx, n);
      s = rx[7:0];
      if (np == 0) chk("poll_first", 64'(s), 64'h01);
      if (s == 8'h00) break;
      if (s != 8'h01) bad = 1;
    end
    chk("poll_done", 64'(s), 64'h00);
    chk("poll_clean", 64'(bad), 64'd0);
    chk("poll_time", 64'(cyc - t0 >= ERASE), 64'd1);
    chk("poll_lc", 64'(last_cmd), 64'h05);
    for (int j = 0; j < 4; j++) begin
      txn({8'h03, BASE + 24'(4 * j), 32'h0}, 64, 0, rx, n);
      chk("erased_rd", 64'(rx[31:0]), 64'hFFFFFFFF);
    end
    txn({8'h06, 56'h0}, 8, 0, rx, n);
    txn({8'h02, 24'h1ffd80, 8'h12, 24'h0}, 40, PROG, rx, n);
    txn({8'h06, 56'h0}, 8, 0, rx, n);
    bus.spi_cs = 1'b0;
    wclk(4);
    shift({8'h03, 24'h1ffd80, 32'h0}, 40, rx);
    chk("pre_rst_rx", 64'(rx[7:0]), 64'h12);
    rst = 1'b1;
    wclk(2);
    rst = 1'b0;
    wclk(1);
    chk("mid_rst_do", 64'(bus.spi_do), 64'd1);
    chk("mid_rst_wel", 64'(wel), 64'd0);
    chk("mid_rst_lc", 64'(last_cmd), 64'd0);
    shift(64'h0, 16, rx);
    chk("post_rst_idle", 64'(rx[15:0]), 64'hFFFF);
    wclk(4);
    bus.spi_cs = 1'b1;
    meas(40, n);
    chk("post_rst_busy", 64'(n), 64'd0);
    wclk(8);
    txn({8'h03, 24'h1ffd80, 32'h0}, 64, 0, rx, n);
    chk("post_rst_mem", 64'(rx[31:0]), 64'hFFFFFFFF);
    for (int i = 0; i < 16; i++) mm[i] = 8'hFF;
    mwel = 0;
    erases = 0;
    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(0, 15);
      a = BASE - 24'd4 + 24'($urandom_range(0, 22));
      d = $urandom;
      nb = 8;
      rd = 0;
      eb = 0;
      ex = '0;
      if (k <= 2) begin
        tx = {8'h06, 56'h0};
        nb = (k == 2) ? 9 : 8;
        if (nb == 8) mwel = 1;
      end else if (k == 3) begin
        tx = {8'h04, 56'h0};
        mwel = 0;
      end else if (k <= 7) begin
        n = $urandom_range(0, 4);
        tx = {8'h02, a, d};
        nb = 32 + 8 * n;
        if (mwel) begin
          for (int i = 0; i < n; i++) begin
            ai = {a[23:8], a[7:0] + 8'(i)};
            mwr(ai, 8'(d >> (24 - 8 * i)));
          end
          if (n > 0) begin
            eb = PROG;
            mwel = 0;
          end
        end
      end else if (k <= 11) begin
        tx = {8'h03, a, 32'h0};
        nb = 64;
        rd = 1;
        ex = {mrd(a), mrd(a + 24'd1), mrd(a + 24'd2), mrd(a + 24'd3)};
      end else if (k <= 13 || erases >= 2) begin
        tx = {8'h05, 56'h0};
        nb = 16;
        rd = 1;
        ex = {16'h0, 8'hFF, 6'b0, mwel, 1'b0};
      end else begin
        erases++;
        a = (k == 14) ? {BASE[23:12], 12'($urandom)} : {12'h100 + 12'($urandom_range(0, 15)), 12'($urandom)};
        tx = {8'h20, a, 32'h0};
        nb = 32;
        if (mwel) begin
          if (a[23:12] == BASE[23:12]) for (int i = 0; i < 16; i++) mm[i] = 8'hFF;
          eb = ERASE;
          mwel = 0;
        end
      end
      txn(tx, nb, eb, rx, n);
      if (rd) chk("rnd_rx", 64'(rx[31:0]), 64'(ex));
      chk("rnd_busy", 64'(n), 64'(eb));
      chk("rnd_wel", 64'(wel), 64'(mwel));
    end
    for (int j = 0; j < 4; j++) begin
      txn({8'h03, BASE + 24'(4 * j), 32'h0}, 64, 0, rx, n);
      chk("final_rd", 64'(rx[31:0]), 64'({mm[4*j], mm[4*j+1], mm[4*j+2], mm[4*j+3]}));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_flash_emu.md
# spi_flash_emu

Synthesizable SPI-flash responder: the device end of the SPI link driven by `spi_flash`. It decodes the subset of serial-NOR commands our controller issues (read, write enable/disable, page program, 4 KB sector erase, read status, release power-down) against a small register-backed byte window at the preset-storage address. It stands in for the physical flash in simulation and in FPGA loopback builds, with a WIP busy timer so retry/wait paths get exercised.

## Interface
- `BASE_ADDR`, 24'h1ffd80: first byte address of the emulated window.
- `MEM_BYTES`, 16: window size in bytes (4 buttons × 4 bytes); power of two, ≤ 256.
- `ERASE_CYCLES`, 4096: clk cycles WIP stays set after a sector erase.
- `PROG_CYCLES`, 256: clk cycles WIP stays set after a page program.
- `clk` in 1: system clock; `spi_clk` must be ≤ clk/8.
- `rst` in 1: reset, synchronous and active-high.
- `spi_clk` in 1: SPI clock from controller (mode 0).
- `spi_cs` in 1: chip select, active low.
- `spi_di` in 1: controller→flash serial data (MOSI).
- `spi_do` out 1: flash→controller serial data (MISO).
- `busy` out 1: WIP status bit.
- `wel` out 1: write-enable-latch status bit.
- `last_cmd` out 8: opcode of most recently decoded command (debug).

## Operation
- `spi_clk`, `spi_cs`, `spi_di` pass through 2-flop synchronizers; rising/falling edges detected in clk domain.
- Mode 0: sample `spi_di` on `spi_clk` rise, MSB first; update `spi_do` on `spi_clk` fall.
- FSM: IDLE → CMD (8 bits) → ADDR (24 bits) → RD / PROG, or STATUS, or IGNORE. `spi_cs` rising from any state → IDLE; partial byte discarded.
- Opcodes: 0x03 read, 0x06 WREN, 0x04 WRDI, 0x02 page program, 0x20 sector erase, 0x05 read status, 0xAB release power-down (no-op). Anything else → IGNORE until CS high.
- While `busy`: only 0x05 decoded; all others → IGNORE, no state change.
- 0x06/0x04 set/clear `wel` at CS rise, only if exactly 8 bits were clocked.
- Read: address increments per byte, wraps at 24 bits; in-window bytes return memory, out-of-window return 0xFF; streams until CS high.
- Status: returns {6'b0, wel, busy}, repeated while CS low.
- Program (needs `wel`): each complete data byte ANDed into window byte at current address (1→0 only); address low byte wraps within 256-byte page; out-of-window bytes ignored. At CS rise, if ≥1 data byte received: `busy`=1 for PROG_CYCLES, `wel`=0.
- Erase (needs `wel`): at CS rise after exactly 32 bits: if addr[23:12]==BASE_ADDR[23:12] set whole window to 0xFF; start `busy` for ERASE_CYCLES regardless; `wel`=0. Wrong bit count → aborted, `wel` kept.
- Program/erase without `wel`: ignored, no busy.
- `busy` clears when counter reaches zero; `wel` unaffected.

## Timing
- Reset: `spi_do`=1, `busy`=0, `wel`=0, `last_cmd`=0, FSM IDLE, all window bytes 0xFF, busy counter 0.
- Reset mid-transfer aborts everything; transaction resumes only after next CS fall.
- `spi_do` changes 3 clk after the `spi_clk` fall on pins (2 sync + 1 register); first read/status bit driven after fall of last address/command bit; `spi_do`=1 while CS high.
- `last_cmd` updates 1 clk after 8th command bit sampled.
- CS rise and `spi_clk` edge in same synchronized cycle: CS wins.
- Busy counter reaching zero and a new 0x05 byte same cycle: status reflects counter value at the sample edge of status bit 0.

## Structure
- `spi_flash_pkg`: opcode localparams, FSM state enum, status-bit positions; shared with `spi_flash`.
- Sub-module `spi_edge_sync`: 2-flop sync of the three SPI inputs plus rise/fall pulse outputs.
- Window stored as flop array `[0:MEM_BYTES-1]` of 8-bit.

## Test plan
- Reset, read 0x03 @0x1ffd80, 4 bytes → FF FF FF FF; `busy`=0.
- WREN, program @0x1ffd84 with B0 2E 7F 1E, CS high → `busy` high PROG_CYCLES, `wel`=0; read → B0 2E 7F 1E.
- Program without WREN @0x1ffd80 with 00 → read still FF; `busy` never set.
- WREN, erase 0x1ffd80; poll 0x05 → 0x01 until ERASE_CYCLES elapse, then 0x00; window reads all FF. Read issued while busy → `spi_do` stays 1, `last_cmd` unchanged.
- Program 0xF0 then 0x0F to same byte (WREN each) → reads 0x00; erase at 0x100000 → busy set, window unchanged.
- CS raised after 20 address bits of erase, and `rst` pulsed mid-read → no erase, `wel` retained (first case), FSM IDLE and `spi_do`=1 (second).
